// File: rtl/acq_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : acq_frame_scheduler
// Purpose  : Paces sensor frame triggers, watches the stream for frame end,
//            and applies a completion timeout in burst or continuous mode.
// Revision : 1.0  initial release
// ============================================================================
module acq_frame_scheduler #(
    parameter int PERIOD_W  = 32,
    parameter int COUNT_W   = 16,
    parameter int TIMEOUT_W = 24
) (
    input  logic                 master_clock,
    input  logic                 resetn,
    input  logic                 cfg_start,
    input  logic                 cfg_stop,
    input  logic                 cfg_mode,
    input  logic [COUNT_W-1:0]   cfg_frame_count,
    input  logic [PERIOD_W-1:0]  cfg_period,
    input  logic [TIMEOUT_W-1:0] cfg_timeout,
    input  logic                 mon_tvalid,
    input  logic                 mon_tready,
    input  logic                 mon_tlast,
    output logic                 acq_trigger,
    output logic                 acq_enable,
    output logic                 busy,
    output logic                 done,
    output logic                 err_timeout,
    output logic [COUNT_W-1:0]   overrun_cnt,
    output logic [COUNT_W-1:0]   frames_done,
    output logic [3:0]           dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_TRIGGER     = 4'd1,
        S_WAIT_FRAME  = 4'd2,
        S_WAIT_PERIOD = 4'd3,
        S_DONE        = 4'd4,
        S_ERROR       = 4'd5
    } state_t;

    state_t               r_state;
    logic                 r_mode;
    logic                 r_stop_pend;
    logic [COUNT_W-1:0]   r_remaining;
    logic [PERIOD_W-1:0]  r_period_m1;
    logic [PERIOD_W-1:0]  r_pcnt;
    logic [TIMEOUT_W-1:0] r_timeout;
    logic [TIMEOUT_W-1:0] r_tcnt;

    logic                 w_frame_end;
    logic                 w_stop;
    logic                 w_period_up;
    logic                 w_last;
    logic                 w_timed_out;
    logic [PERIOD_W-1:0]  w_pcnt_inc;
    logic [TIMEOUT_W-1:0] w_tcnt_inc;

    // Both counters hold "cycles since the trigger cycle", so reaching
    // period-1 in WAIT_PERIOD re-triggers exactly one period later.
    assign w_frame_end = mon_tvalid & mon_tready & mon_tlast;
    assign w_stop      = r_stop_pend | cfg_stop;
    assign w_period_up = (r_pcnt >= r_period_m1);
    assign w_last      = ~r_mode & (r_remaining == '0);
    assign w_timed_out = (r_timeout != '0) && (r_tcnt == r_timeout - TIMEOUT_W'(1));
    assign w_pcnt_inc  = (r_pcnt == '1) ? r_pcnt : r_pcnt + PERIOD_W'(1);
    assign w_tcnt_inc  = (r_tcnt == '1) ? r_tcnt : r_tcnt + TIMEOUT_W'(1);
    assign dbg_state   = r_state;

    always_ff @(posedge master_clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_mode      <= 1'b0;
            r_stop_pend <= 1'b0;
            r_remaining <= '0;
            r_period_m1 <= '0;
            r_pcnt      <= '0;
            r_timeout   <= '0;
            r_tcnt      <= '0;
            acq_trigger <= 1'b0;
            acq_enable  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            overrun_cnt <= '0;
            frames_done <= '0;
        end else begin
            acq_trigger <= 1'b0;
            done        <= 1'b0;
            r_pcnt      <= w_pcnt_inc;
            r_tcnt      <= w_tcnt_inc;
            if (cfg_stop && (r_state != S_IDLE)) begin
                r_stop_pend <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (cfg_start) begin
                        r_mode      <= cfg_mode;
                        r_remaining <= (cfg_frame_count == '0) ? COUNT_W'(1) : cfg_frame_count;
                        r_period_m1 <= (cfg_period < PERIOD_W'(2)) ? PERIOD_W'(1)
                                                                   : cfg_period - PERIOD_W'(1);
                        r_timeout   <= cfg_timeout;
                        r_stop_pend <= 1'b0;
                        frames_done <= '0;
                        overrun_cnt <= '0;
                        err_timeout <= 1'b0;
                        r_pcnt      <= '0;
                        r_tcnt      <= '0;
                        acq_trigger <= 1'b1;
                        acq_enable  <= 1'b1;
                        busy        <= 1'b1;
                        r_state     <= S_TRIGGER;
                    end
                end

                S_TRIGGER: begin
                    r_remaining <= r_remaining - COUNT_W'(1);
                    r_state     <= S_WAIT_FRAME;
                end

                S_WAIT_FRAME: begin
                    if (w_frame_end) begin
                        frames_done <= frames_done + COUNT_W'(1);
                        if (w_period_up && (overrun_cnt != '1)) begin
                            overrun_cnt <= overrun_cnt + COUNT_W'(1);
                        end
                        if (w_last || w_stop) begin
                            done       <= 1'b1;
                            acq_enable <= 1'b0;
                            r_state    <= S_DONE;
                        end else if (w_period_up) begin
                            acq_trigger <= 1'b1;
                            r_pcnt      <= '0;
                            r_tcnt      <= '0;
                            r_state     <= S_TRIGGER;
                        end else begin
                            r_state <= S_WAIT_PERIOD;
                        end
                    end else if (w_timed_out) begin
                        acq_enable <= 1'b0;
                        r_state    <= S_ERROR;
                    end
                end

                S_WAIT_PERIOD: begin
                    if (w_stop) begin
                        done       <= 1'b1;
                        acq_enable <= 1'b0;
                        r_state    <= S_DONE;
                    end else if (w_period_up) begin
                        acq_trigger <= 1'b1;
                        r_pcnt      <= '0;
                        r_tcnt      <= '0;
                        r_state     <= S_TRIGGER;
                    end
                end

                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                S_ERROR: begin
                    err_timeout <= 1'b1;
                    busy        <= 1'b0;
                    r_state     <= S_IDLE;
                end

                default: begin
                    acq_enable <= 1'b0;
                    busy       <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/acq_frame_scheduler.md
# acq_frame_scheduler

Frame-level controller for the sensor acquisition path. It sequences S15611 frame captures by issuing one-cycle trigger pulses at a programmed frame period and watching the packet stream for frame completion. It enforces a completion timeout and supports burst (N frames) and continuous modes. It sits between the PS-side control registers and the acquisition block, monitoring that block's AXI-Stream output without modifying it.

## Interface
- PERIOD_W, 32, width of frame-period counter
- COUNT_W, 16, width of frame counters
- TIMEOUT_W, 24, width of completion-timeout counter

- master_clock  in  1  40 MHz system clock; all logic on its rising edge
- resetn  in  1  asynchronous, active-low reset
- cfg_start  in  1  one-cycle start pulse; honoured only in IDLE
- cfg_stop  in  1  one-cycle graceful-stop pulse; honoured in any active state
- cfg_mode  in  1  0 = burst of cfg_frame_count frames, 1 = continuous
- cfg_frame_count  in  COUNT_W  burst length; 0 treated as 1
- cfg_period  in  PERIOD_W  trigger-to-trigger spacing in clocks; values <2 treated as 2
- cfg_timeout  in  TIMEOUT_W  max clocks from trigger to frame end; 0 disables the timeout
- mon_tvalid, mon_tready, mon_tlast  in  1 each  monitored stream handshake
- acq_trigger  out  1  one-cycle frame-start pulse to the acquisition block
- acq_enable  out  1  high from start until DONE/ERROR
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on normal completion
- err_timeout  out  1  sticky timeout flag; cleared by the next accepted cfg_start
- overrun_cnt  out  COUNT_W  frames whose completion arrived after their period expired
- frames_done  out  COUNT_W  completed frames since the last start; wraps at 2^COUNT_W
- dbg_state  out  4  current FSM state encoding

## Operation
- All configuration inputs are latched on the accepted cfg_start. Later changes have no effect until the next start.
- Frame end is the cycle where mon_tvalid & mon_tready & mon_tlast are all high.
- State encodings: IDLE=0, TRIGGER=1, WAIT_FRAME=2, WAIT_PERIOD=3, DONE=4, ERROR=5.
- IDLE: on cfg_start, latch the configuration, clear frames_done, overrun_cnt and err_timeout, then go to TRIGGER.
- TRIGGER (one cycle):
  - Period counter and timeout counter load 0.
  - Remaining-frame counter decrements.
  - Next state is WAIT_FRAME.
- WAIT_FRAME:
  - Period and timeout counters increment.
  - On frame end: frames_done+1. If the period counter is at or past period-1 at that point, overrun_cnt+1 (saturating).
  - After a frame end, the next state is:
    - DONE, if this was the last burst frame or a stop is pending;
    - TRIGGER, if the period has elapsed;
    - WAIT_PERIOD, otherwise.
  - If the timeout counter reaches cfg_timeout-1 (with cfg_timeout ≠ 0) and no frame end occurs that cycle, go to ERROR. A frame end in that same cycle wins.
- WAIT_PERIOD: go to TRIGGER when the period counter reaches period-1, so consecutive triggers are exactly `period` cycles apart. A pending stop goes to DONE instead.
- cfg_stop sets a stop-pending flag. The current frame is always allowed to finish. A stop in IDLE is ignored.
- DONE: done=1 for one cycle, acq_enable drops, then go to IDLE.
- ERROR: err_timeout=1, acq_enable drops, then go to IDLE the next cycle.
- Stray frame ends seen in IDLE or WAIT_PERIOD are ignored and not counted.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state = IDLE;
  - all outputs 0, including counters, flags and dbg_state.
- All outputs are registered.
- cfg_start sampled in cycle N gives acq_trigger=1, busy=1 and acq_enable=1 in cycle N+1.
- Frame end in cycle M with the period already elapsed gives acq_trigger in cycle M+1.
- Frame end on the last burst frame in cycle M gives done in cycle M+1 and busy=0 in cycle M+2.
- Timeout: with no frame end, ERROR is entered cfg_timeout cycles after the trigger cycle, and err_timeout is high one cycle later.
- cfg_start and cfg_stop in the same IDLE cycle: the start is accepted and the stop is ignored.
- Reset mid-frame aborts immediately. No done pulse is issued and no trigger is emitted.

## Test plan
- Burst: mode=0, count=3, period=100, frame end 40 cycles after each trigger -> 3 triggers exactly 100 cycles apart, frames_done=3, one done pulse, overrun_cnt=0.
- Overrun: count=2, period=10, frame end 25 cycles after the trigger -> second trigger the cycle after that frame end, overrun_cnt=1.
- Timeout: timeout=50, no tlast -> ERROR 50 cycles after the trigger, err_timeout=1, acq_enable=0, no done pulse; the next cfg_start clears err_timeout.
- Continuous + stop: mode=1, period=64, cfg_stop mid-frame -> that frame completes, frames_done increments, done pulse, no further trigger.
- Backpressure: tlast held with tready=0 for 20 cycles -> frame end counted only on the tready cycle, exactly once.
- Async reset asserted in WAIT_FRAME -> all outputs 0 immediately, no trigger after release until a new cfg_start.
